// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   BAUD_DIV    - clock divider for 115200 baud from a 50 MHz clock
//   UART_DATA_W - data byte width
//   txq_state_t - transmit-queue launch FSM states
package uart_pkg;

    localparam int unsigned BAUD_DIV    = 434;
    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } txq_state_t;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: circular-buffer byte FIFO with registered occupancy flags.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   wr_en, wr_data - write strobe/byte (ignored while full)
//   rd_en          - pop strobe (ignored while empty)
//   rd_data        - head entry (valid while empty=0)
//   full, empty    - registered occupancy flags
//   count          - registered occupancy, 0..DEPTH
module uart_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [UART_DATA_W-1:0]     wr_data,
    input  logic                       rd_en,
    output logic [UART_DATA_W-1:0]     rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count_nxt;
    logic                   push;
    logic                   pop;

    // Acceptance uses the pre-edge flags, so a write while full is dropped
    // even when a pop frees a slot in the same cycle.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally: DEPTH is a power of two and the pointers are AW bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue feeding a UART transmit serializer.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   wr_en, wr_data  - CPU byte write (dropped while full)
//   full, empty     - registered queue flags
//   count           - registered queue occupancy
//   tx_busy         - busy flag from the serializer
//   tx_begin        - one-cycle launch pulse to the serializer
//   tx_data         - launched byte, held until the next launch
// Optional (macro UART_TXQ_OVERFLOW_FLAG_EN):
//   ovf_clr         - clears the sticky overflow flag
//   ovf             - sticky flag, set by any dropped write (set wins)
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned GUARD_CYC = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [UART_DATA_W-1:0]     wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       tx_busy,
    output logic                       tx_begin,
    output logic [UART_DATA_W-1:0]     tx_data
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
    ,
    input  logic                       ovf_clr,
    output logic                       ovf
`endif
);

    localparam int unsigned GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    txq_state_t             state;
    logic [GW-1:0]          guard_cnt;
    logic [UART_DATA_W-1:0] head;
    logic                   pop;

    assign pop = (state == IDLE) && !empty && !tx_busy;

    uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // tx_begin is registered alongside the state, so it is high exactly
    // while the FSM sits in LAUNCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_begin  <= 1'b0;
            tx_data   <= '0;
            guard_cnt <= '0;
        end else begin
            tx_begin <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= head;
                        tx_begin <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    guard_cnt <= '0;
                    state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Serializer never acknowledged: give up after GUARD_CYC
                    // cycles and treat the byte as sent.
                    if (tx_busy) begin
                        guard_cnt <= '0;
                        state     <= WAIT_DONE;
                    end else if (guard_cnt == GW'(GUARD_CYC - 1)) begin
                        guard_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVERFLOW_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: self-checking bench for uart_tx_queue.
// A queue-based reference model predicts every output each cycle; directed
// scenarios add literal expectations, followed by a randomized phase.
module tb_uart_tx_queue;

    localparam int DEPTH = 8;
    localparam int GUARD = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       tx_begin;
    logic [7:0] tx_data;
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
    logic       ovf_clr = 1'b0;
    logic       ovf;
`endif

    uart_tx_queue #(
        .DEPTH     (DEPTH),
        .GUARD_CYC (GUARD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_busy  (tx_busy),
        .tx_begin (tx_begin),
        .tx_data  (tx_data)
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
        ,
        .ovf_clr  (ovf_clr),
        .ovf      (ovf)
`endif
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Queue contents plus the launch bookkeeping: a launched byte stays
    // "in flight" until the serializer has been seen busy and then idle,
    // or until GUARD cycles pass without it going busy.
    logic [7:0] mq[$];
    bit         m_launch = 0;
    bit         m_inflight = 0;
    bit         m_seen_busy = 0;
    int         m_guard_left = 0;
    logic [7:0] m_data = 8'h00;
    bit         m_ovf = 0;
    bit         pre_full, pre_empty;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            m_launch = 0;
            m_inflight = 0;
            m_seen_busy = 0;
            m_guard_left = 0;
            m_data = 8'h00;
            m_ovf = 0;
        end else begin
            pre_full  = (mq.size() == DEPTH);
            pre_empty = (mq.size() == 0);
            if (m_launch) begin
                m_launch = 0;
                m_inflight = 1;
                m_seen_busy = 0;
                m_guard_left = GUARD;
            end else if (m_inflight) begin
                if (m_seen_busy) begin
                    if (!tx_busy) m_inflight = 0;
                end else if (tx_busy) begin
                    m_seen_busy = 1;
                end else begin
                    m_guard_left--;
                    if (m_guard_left == 0) m_inflight = 0;
                end
            end else if (!pre_empty && !tx_busy) begin
                m_data = mq.pop_front();
                m_launch = 1;
            end
            if (wr_en && !pre_full) mq.push_back(wr_data);
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
            if (wr_en && pre_full) m_ovf = 1;
            else if (ovf_clr)      m_ovf = 0;
`endif
        end
    end

    // ---------------- compare + launch logger ----------------
    int         launches = 0;
    logic [7:0] launch_log[$];
    int         launch_cyc[$];

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("count",    32'(count),    32'(mq.size()));
            check("empty",    32'(empty),    32'(mq.size() == 0));
            check("full",     32'(full),     32'(mq.size() == DEPTH));
            check("tx_begin", 32'(tx_begin), 32'(m_launch));
            check("tx_data",  32'(tx_data),  32'(m_data));
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
            check("ovf",      32'(ovf),      32'(m_ovf));
`endif
        end
        if (tx_begin === 1'b1) begin
            launches++;
            launch_log.push_back(tx_data);
            launch_cyc.push_back(cyc);
        end
    end

    // ---------------- serializer model ----------------
    // 0: never busy, 1: always busy, 2: busy 1 cycle after tx_begin for
    // busy_len cycles, 3: random
    int tx_mode = 0;
    int busy_len = 4340;
    int busy_left = 0;

    initial begin
        bit b;
        forever begin
            @(negedge clk);
            b = tx_begin;
            @(posedge clk);
            #1;
            case (tx_mode)
                0: begin tx_busy = 1'b0; busy_left = 0; end
                1: begin tx_busy = 1'b1; busy_left = 0; end
                2: begin
                    if (b) begin
                        tx_busy = 1'b1;
                        busy_left = busy_len;
                    end else if (busy_left > 0) begin
                        busy_left--;
                        if (busy_left == 0) tx_busy = 1'b0;
                    end else begin
                        tx_busy = 1'b0;
                    end
                end
                default: tx_busy = ($urandom_range(0, 99) < 40);
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_launches(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (launches < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(launches >= target), 32'd1);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int base;
        int n;

        // Reset state and two-cycle launch latency
        tx_mode = 0;
        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_tx_begin", 32'(tx_begin), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        write_byte(8'h41);
        check("lat_no_begin_yet", 32'(tx_begin), 32'd0);
        check("lat_not_empty", 32'(empty), 32'd0);
        tick();
        check("lat_begin", 32'(tx_begin), 32'd1);
        check("lat_data", 32'(tx_data), 32'h41);
        check("lat_empty", 32'(empty), 32'd1);
        tick();
        check("lat_pulse_one", 32'(tx_begin), 32'd0);

        // Fill with serializer busy, then overflow
        tx_mode = 1;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        write_byte(8'h09);
        check("ovf_count", 32'(count), 32'd8);
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
        check("ovf_set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'd0);
`endif

        // Drain through a serializer that is busy for 4340 cycles per byte
        launch_log.delete();
        base = launches;
        busy_len = 4340;
        tx_mode = 2;
        wait_launches("drain_progress", base + 8, 8 * 4400 + 200);
        n = 0;
        while (tx_busy && n < 4500) begin
            tick();
            n++;
        end
        repeat (30) tick();
        check("drain_launch_count", 32'(launches - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < launch_log.size())
                check("drain_order", 32'(launch_log[i]), 32'(i + 1));
            else
                check("drain_missing", 32'(launch_log.size()), 32'd8);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Serializer never goes busy: guard timeout releases the next byte
        tx_mode = 0;
        do_reset();
        launch_log.delete();
        launch_cyc.delete();
        base = launches;
        write_byte(8'hA0);
        write_byte(8'hA1);
        wait_launches("guard_progress", base + 2, 100);
        if (launch_cyc.size() >= 2) begin
            check("guard_gap", 32'(launch_cyc[1] - launch_cyc[0]), 32'(GUARD + 2));
            check("guard_byte0", 32'(launch_log[0]), 32'hA0);
            check("guard_byte1", 32'(launch_log[1]), 32'hA1);
        end else begin
            check("guard_launches", 32'(launch_cyc.size()), 32'd2);
        end

        // Reset while the serializer is busy with 5 bytes still queued
        busy_len = 50;
        tx_mode = 2;
        do_reset();
        base = launches;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h30 + i);
            tick();
        end
        wr_en = 1'b0;
        wait_launches("mid_first_launch", base + 1, 50);
        repeat (3) tick();
        check("mid_queued", 32'(count), 32'd5);
        check("mid_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        base = launches;
        repeat (80) tick();
        check("mid_no_relaunch", 32'(launches - base), 32'd0);
        write_byte(8'h5A);
        wait_launches("mid_new_launch", base + 1, 50);
        check("mid_new_data", 32'(tx_data), 32'h5A);
        repeat (60) tick();

        // Full queue with simultaneous write and pop: write dropped
        tx_mode = 1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h70 + i);
            tick();
        end
        wr_en = 1'b0;
        tx_mode = 0;
        tick();
        wr_en = 1'b1;
        wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        check("wp_full_count", 32'(count), 32'd7);
        check("wp_full_flag", 32'(full), 32'd0);
        check("wp_launch_data", 32'(tx_data), 32'h70);
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
        check("wp_ovf", 32'(ovf), 32'd1);
`endif

        // Randomized traffic against the model
        for (int phase = 0; phase < 2; phase++) begin
            busy_len = 6;
            tx_mode = (phase == 0) ? 3 : 2;
            do_reset();
            for (int i = 0; i < 2000; i++) begin
                wr_en   = ($urandom_range(0, 99) < 45);
                wr_data = 8'($urandom);
                rst     = ($urandom_range(0, 499) == 0);
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
                ovf_clr = ($urandom_range(0, 7) == 0);
`endif
                tick();
            end
            wr_en = 1'b0;
            rst = 1'b0;
`ifdef UART_TXQ_OVERFLOW_FLAG_EN
            ovf_clr = 1'b0;
`endif
            repeat (20) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
